// File: rtl/instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
//
// Purpose:
//   Single-entry RV32I decode stage. It holds one instruction and its pc,
//   presents the register-file read addresses, and produces a decoded payload
//   (operands, immediate, rd, opcode fields, regwrite, illegal) for downstream.
//   The register file is synchronous: data for an address presented before an
//   edge is returned on rf_rdataX after that edge.
//
// Optional feature:
//   WB_BYPASS_EN - when defined, a writeback that targets a register being
//                  read in the same cycle is captured and forwarded in place
//                  of the (stale) register-file read data.
//
// Parameters:
//   NOP_INSTR     instruction held after reset and after flush
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   in_valid      upstream instruction valid
//   in_ready      stage can take an instruction (!out_valid || out_ready)
//   in_instr      upstream instruction word
//   in_pc         upstream instruction pc
//   rf_raddr1/2   register-file read addresses (rs1/rs2)
//   rf_rdata1/2   register-file read data, one cycle after the address
//   wb_we         writeback enable (mirror of register-file write port)
//   wb_rd         writeback destination
//   wb_data       writeback data
//   flush         synchronous pipeline kill, dominant over accept
//   out_valid     downstream payload valid
//   out_ready     downstream can take the payload
//   out_pc        held pc
//   out_rs1_val   rs1 operand (0 for x0)
//   out_rs2_val   rs2 operand (0 for x0)
//   out_imm       sign-extended immediate (0 for types without one)
//   out_rd        destination register field
//   out_opcode    opcode field
//   out_funct3    funct3 field
//   out_funct7b5  instr[30]
//   out_regwrite  instruction writes rd (never for rd = x0)
//   out_illegal   opcode not recognised or instr[1:0] != 2'b11
// -----------------------------------------------------------------------------
module instr_decode #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,

    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,

    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,

    input  logic        flush,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_rs1_val,
    output logic [31:0] out_rs2_val,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rd,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic        out_funct7b5,
    output logic        out_regwrite,
    output logic        out_illegal
);

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic        accept;

    // ------------------------------------------------------------------
    // Handshake and holding register
    // ------------------------------------------------------------------
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
        end else if (accept) begin
            valid_q <= 1'b1;
            instr_q <= in_instr;
            pc_q    <= in_pc;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Addresses follow the incoming instruction on accept so its operands
    // arrive with it; otherwise the held fields keep the read data current
    // while stalled.
    assign rf_raddr1 = accept ? in_instr[19:15] : instr_q[19:15];
    assign rf_raddr2 = accept ? in_instr[24:20] : instr_q[24:20];

    // ------------------------------------------------------------------
    // Operand sources (optional writeback bypass)
    // ------------------------------------------------------------------
    logic [31:0] rs1_src;
    logic [31:0] rs2_src;

`ifdef WB_BYPASS_EN
    logic        byp1_q;
    logic        byp2_q;
    logic [31:0] byp_data_q;

    // The register file returns the pre-write value when a read and a write
    // to the same register share a cycle; remember that write and use it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byp1_q     <= 1'b0;
            byp2_q     <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp1_q     <= wb_we && (wb_rd != '0) && (wb_rd == rf_raddr1);
            byp2_q     <= wb_we && (wb_rd != '0) && (wb_rd == rf_raddr2);
            byp_data_q <= wb_data;
        end
    end

    assign rs1_src = byp1_q ? byp_data_q : rf_rdata1;
    assign rs2_src = byp2_q ? byp_data_q : rf_rdata2;
`else
    logic unused_wb;

    assign unused_wb = ^{wb_we, wb_rd, wb_data};
    assign rs1_src   = rf_rdata1;
    assign rs2_src   = rf_rdata2;
`endif

    assign out_rs1_val = (instr_q[19:15] == '0) ? '0 : rs1_src;
    assign out_rs2_val = (instr_q[24:20] == '0) ? '0 : rs2_src;

    // ------------------------------------------------------------------
    // Decode of the held instruction
    // ------------------------------------------------------------------
    logic [31:0] imm;
    logic        writes_rd;
    logic        legal;

    always_comb begin
        imm       = '0;
        writes_rd = 1'b0;
        legal     = 1'b0;
        case (instr_q[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                imm       = {{20{instr_q[31]}}, instr_q[31:20]};
                writes_rd = 1'b1;
                legal     = 1'b1;
            end
            OP_STORE: begin
                imm   = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
                legal = 1'b1;
            end
            OP_BRANCH: begin
                imm   = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                         instr_q[30:25], instr_q[11:8], 1'b0};
                legal = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm       = {instr_q[31:12], 12'h000};
                writes_rd = 1'b1;
                legal     = 1'b1;
            end
            OP_JAL: begin
                imm       = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                             instr_q[20], instr_q[30:21], 1'b0};
                writes_rd = 1'b1;
                legal     = 1'b1;
            end
            OP_REG: begin
                writes_rd = 1'b1;
                legal     = 1'b1;
            end
            default: begin
                imm       = '0;
                writes_rd = 1'b0;
                legal     = 1'b0;
            end
        endcase
        if (instr_q[1:0] != 2'b11) begin
            writes_rd = 1'b0;
            legal     = 1'b0;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = pc_q;
    assign out_imm      = imm;
    assign out_rd       = instr_q[11:7];
    assign out_opcode   = instr_q[6:0];
    assign out_funct3   = instr_q[14:12];
    assign out_funct7b5 = instr_q[30];
    assign out_regwrite = writes_rd && (instr_q[11:7] != '0);
    assign out_illegal  = !legal;

endmodule

// File: tb/tb_instr_decode.sv
// -----------------------------------------------------------------------------
// tb_instr_decode
//
// Purpose:
//   Directed self-checking bench for instr_decode. Includes a small
//   synchronous register-file model (read data one cycle after address,
//   read-before-write on a same-cycle writeback). Register x0 in the model
//   holds a non-zero pattern so the x0 operand forcing is observable.
//   Build with or without WB_BYPASS_EN; the bypass expectation follows it.
// -----------------------------------------------------------------------------
module tb_instr_decode;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [31:0] out_imm;
    logic [4:0]  out_rd;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
    logic        out_regwrite;
    logic        out_illegal;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clock = ~clock;

    instr_decode #(.NOP_INSTR(32'h0000_0013)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .rf_raddr1    (rf_raddr1),
        .rf_raddr2    (rf_raddr2),
        .rf_rdata1    (rf_rdata1),
        .rf_rdata2    (rf_rdata2),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rs1_val  (out_rs1_val),
        .out_rs2_val  (out_rs2_val),
        .out_imm      (out_imm),
        .out_rd       (out_rd),
        .out_opcode   (out_opcode),
        .out_funct3   (out_funct3),
        .out_funct7b5 (out_funct7b5),
        .out_regwrite (out_regwrite),
        .out_illegal  (out_illegal)
    );

    // Register-file model: x0 = BAD00000, x1 = 0, xN = 100+N.
    logic [31:0] regs [32];

    function automatic logic [31:0] rf_init(input int unsigned idx);
        if (idx == 0)      return 32'hBAD0_0000;
        else if (idx == 1) return 32'h0000_0000;
        else               return 32'h0000_0100 + idx;
    endfunction

    always @(posedge clock) begin
        rf_rdata1 <= regs[rf_raddr1];
        rf_rdata2 <= regs[rf_raddr2];
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++) regs[i] <= rf_init(i);
        end else if (wb_we) begin
            regs[wb_rd] <= wb_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Decode table: instruction, immediate, regwrite, illegal.
    // FE208EE3 is beq x1,x2,-4 (imm FFFFFFFC); FE208E63 clears instr[7]
    // giving the -2052 branch offset FFFFF7FC.
    localparam int NT = 10;
    logic [31:0] t_instr [NT] = '{32'hFE208EE3, 32'hFE208E63, 32'h0000006F, 32'hFFDFF0EF,
                                 32'h123452B7, 32'hFE20AC23, 32'hFFF12303, 32'h0000007F,
                                 32'h000000FF, 32'h00A00090};
    logic [31:0] t_imm   [NT] = '{32'hFFFFFFFC, 32'hFFFFF7FC, 32'h00000000, 32'hFFFFFFFC,
                                 32'h12345000, 32'hFFFFFFF8, 32'hFFFFFFFF, 32'h00000000,
                                 32'h00000000, 32'h00000000};
    logic        t_rw    [NT] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        t_ill   [NT] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    logic [31:0] exp_byp;

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        wb_we     = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;

        // Reset state, with an offered instruction that must be ignored
        #1;
        check("rst_valid_async", {31'b0, out_valid}, 32'd0);
        in_valid = 1'b1;
        in_instr = 32'h00A00093;
        in_pc    = 32'h0000_0050;
        step();
        step();
        check("rst_valid_held", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_pc", out_pc, 32'd0);
        check("rst_imm_nop", out_imm, 32'd0);
        check("rst_opcode_nop", {25'b0, out_opcode}, 32'h13);
        check("rst_regwrite", {31'b0, out_regwrite}, 32'd0);
        check("rst_illegal", {31'b0, out_illegal}, 32'd0);
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        check("idle_valid", {31'b0, out_valid}, 32'd0);

        // addi x1,x0,10 at pc 0x100
        in_valid = 1'b1;
        in_instr = 32'h00A00093;
        in_pc    = 32'h0000_0100;
        #1;
        check("addi_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("addi_valid", {31'b0, out_valid}, 32'd1);
        check("addi_imm", out_imm, 32'd10);
        check("addi_rd", {27'b0, out_rd}, 32'd1);
        check("addi_regwrite", {31'b0, out_regwrite}, 32'd1);
        check("addi_rs1_x0", out_rs1_val, 32'd0);
        check("addi_pc", out_pc, 32'h100);

        // add x3,x1,x2 then stall three cycles with sub x4,x3,x2 offered
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        in_pc    = 32'h0000_0104;
        step();
        in_instr  = 32'h40218233;
        in_pc     = 32'h0000_0108;
        out_ready = 1'b0;
        #1;
        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        check("stall_raddr1", {27'b0, rf_raddr1}, 32'd1);
        check("stall_raddr2", {27'b0, rf_raddr2}, 32'd2);
        check("add_rs2_val", out_rs2_val, 32'h102);
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_valid", {31'b0, out_valid}, 32'd1);
            check("stall_pc", out_pc, 32'h104);
            check("stall_rs2_val", out_rs2_val, 32'h102);
            check("stall_rd", {27'b0, out_rd}, 32'd3);
            check("stall_in_ready_hold", {31'b0, in_ready}, 32'd0);
            check("stall_raddr2_hold", {27'b0, rf_raddr2}, 32'd2);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {31'b0, in_ready}, 32'd1);
        check("release_raddr1", {27'b0, rf_raddr1}, 32'd3);
        step();
        check("sub_valid_no_bubble", {31'b0, out_valid}, 32'd1);
        check("sub_pc", out_pc, 32'h108);
        check("sub_rd", {27'b0, out_rd}, 32'd4);
        check("sub_funct7b5", {31'b0, out_funct7b5}, 32'd1);
        check("sub_rs1_val", out_rs1_val, 32'h103);
        check("sub_rs2_val", out_rs2_val, 32'h102);

        // Back-to-back decode table
        for (int i = 0; i < NT; i++) begin
            in_valid = 1'b1;
            in_instr = t_instr[i];
            in_pc    = 32'h0000_0200 + 32'(i * 4);
            step();
            check("tbl_valid", {31'b0, out_valid}, 32'd1);
            check("tbl_imm", out_imm, t_imm[i]);
            check("tbl_regwrite", {31'b0, out_regwrite}, {31'b0, t_rw[i]});
            check("tbl_illegal", {31'b0, out_illegal}, {31'b0, t_ill[i]});
        end

        // Flush with a simultaneous offer while out_valid=1
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h00A00093;
        in_pc    = 32'h0000_0300;
        #1;
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_nop_opcode", {25'b0, out_opcode}, 32'h13);
        check("flush_nop_rd", {27'b0, out_rd}, 32'd0);
        step();
        check("flush_dropped", {31'b0, out_valid}, 32'd0);

        // Writeback to x1 in the accept cycle of add x3,x1,x2
        in_valid = 1'b1;
        in_instr = 32'h002081B3;
        in_pc    = 32'h0000_0400;
        wb_we    = 1'b1;
        wb_rd    = 5'd1;
        wb_data  = 32'hDEADBEEF;
        step();
        in_valid = 1'b0;
        wb_we    = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
`ifdef WB_BYPASS_EN
        exp_byp = 32'hDEADBEEF;
`else
        exp_byp = 32'h0000_0000;
`endif
        check("bypass_rs1", out_rs1_val, exp_byp);
        check("bypass_rs2", out_rs2_val, 32'h102);
        step();
        check("drain_valid", {31'b0, out_valid}, 32'd0);

        // Reset asserted mid-stall discards the pending instruction
        in_valid = 1'b1;
        in_instr = 32'h123452B7;
        in_pc    = 32'h0000_0500;
        step();
        out_ready = 1'b0;
        in_instr  = 32'h00A00093;
        in_pc     = 32'h0000_0504;
        step();
        check("mid_stall_valid", {31'b0, out_valid}, 32'd1);
        check("mid_stall_imm", out_imm, 32'h12345000);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_pc", out_pc, 32'd0);
        check("async_rst_imm", out_imm, 32'd0);
        check("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("post_rst_valid", {31'b0, out_valid}, 32'd0);
        step();
        check("post_rst_idle", {31'b0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
